// File: rtl/cic_frame_buffer.sv
// cic_frame_buffer
//
// Ping-pong frame buffer between the two CIC decimators and the I2C slave
// transmitter. One {ch1, ch2} pair is captured per fdown tick into the write
// bank. After FRAME_LEN pairs the write bank is published to the I2C side as a
// stable, indexed read bank guarded by a frame_ready / frame_ack handshake.
// Everything runs in the sys_clk domain; fdown is only ever used as a
// synchronised strobe source, never as a clock.
//
// Optional feature (macro CIC_FRAME_HDR_EN):
//   defined   - rd_idx == FRAME_LEN returns a header word
//               {16'hA55A, seq[7:0], drop_cnt[7:0], zero pad}, where seq is
//               the publish sequence number of the current read bank.
//   undefined - no sequence counter is built; rd_idx >= FRAME_LEN returns 0.
//
// Ports:
//   sys_clk      in   1      system clock, sole clock of the block
//   rst_n        in   1      asynchronous active-low reset
//   en           in   1      capture enable; low discards any partial frame
//   fdown        in   1      CIC decimation clock, used as an async strobe
//   cic_out1     in   SW     channel-1 CIC output
//   cic_out2     in   SW     channel-2 CIC output
//   rd_idx       in   IW     read index from the I2C slave
//   rd_data      out  2*SW   registered read-bank word {ch1, ch2} at rd_idx
//   frame_ready  out  1      read bank holds an unacknowledged frame
//   frame_ack    in   1      one-cycle pulse: I2C side is done with the bank
//   drop_cnt     out  8      saturating count of discarded frames
//   wr_level     out  IW     pairs written into the current write bank

module cic_frame_buffer #(
  parameter int unsigned OSR       = 64,
  parameter int unsigned BIT       = 12,
  parameter int unsigned FRAME_LEN = 36,
  localparam int unsigned SW       = BIT + 2 * $clog2(OSR),
  localparam int unsigned IW       = $clog2(FRAME_LEN + 1)
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fdown,
  input  logic [SW-1:0]     cic_out1,
  input  logic [SW-1:0]     cic_out2,
  input  logic [IW-1:0]     rd_idx,
  output logic [2*SW-1:0]   rd_data,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic [7:0]        drop_cnt,
  output logic [IW-1:0]     wr_level
);

  // Address width of one bank; IW can be one bit wider when FRAME_LEN is a
  // power of two, so bank addressing uses the low AW bits only.
  localparam int unsigned AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [0:0] {StEmpty, StReady} state_e;

  // ---------------------------------------------------------------------------
  // fdown synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic r_fd_s1, r_fd_s2, r_fd_s3;
  logic w_tick;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fd_s1 <= 1'b0;
      r_fd_s2 <= 1'b0;
      r_fd_s3 <= 1'b0;
    end else begin
      r_fd_s1 <= fdown;
      r_fd_s2 <= r_fd_s1;
      r_fd_s3 <= r_fd_s2;
    end
  end

  // Combinational tick so the write (and any publish) lands on the third
  // sys_clk edge after the fdown rise.
  assign w_tick = r_fd_s2 & ~r_fd_s3;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic [IW-1:0] r_wr_ptr;
  logic          r_bank_sel;    // bank currently owned by the read side
  logic          w_wr_en;
  logic          w_last;
  logic          w_frame_done;
  logic [AW-1:0] w_wr_addr;
  logic          w_wr_bank;

  assign w_wr_en      = w_tick & en;
  assign w_last       = (r_wr_ptr == IW'(FRAME_LEN - 1));
  assign w_frame_done = w_wr_en & w_last;
  assign w_wr_addr    = r_wr_ptr[AW-1:0];
  assign w_wr_bank    = ~r_bank_sel;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (!en) begin
      // Partial frame is abandoned; the read side keeps whatever it has.
      r_wr_ptr <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr <= w_last ? '0 : r_wr_ptr + 1'b1;
    end
  end

  // Two banks of FRAME_LEN words; no reset, contents are don't-care.
  logic [2*SW-1:0] r_mem [2][FRAME_LEN];

  always_ff @(posedge sys_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_bank][w_wr_addr] <= {cic_out1, cic_out2};
    end
  end

  // ---------------------------------------------------------------------------
  // Read-side handshake FSM
  // ---------------------------------------------------------------------------
  state_e r_state, w_state_nxt;
  logic   w_swap;
  logic   w_drop;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      StEmpty: begin
        // frame_ack here is meaningless and ignored.
        if (w_frame_done) begin
          w_swap      = 1'b1;
          w_state_nxt = StReady;
        end
      end
      StReady: begin
        if (frame_ack) begin
          // Ack wins over a simultaneous completion, which then publishes
          // straight away and keeps frame_ready high.
          if (w_frame_done) begin
            w_swap = 1'b1;
          end else begin
            w_state_nxt = StEmpty;
          end
        end else if (w_frame_done) begin
          // Reader still busy: the finished write bank is simply refilled.
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = StEmpty;
    endcase
  end

  logic [7:0] r_drop_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_sel <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_swap) begin
        r_bank_sel <= ~r_bank_sel;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

`ifdef CIC_FRAME_HDR_EN
  // r_seq_cnt numbers the next publish; r_rd_seq tags the current read bank.
  logic [7:0] r_seq_cnt;
  logic [7:0] r_rd_seq;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_cnt <= '0;
      r_rd_seq  <= '0;
    end else if (w_swap) begin
      r_seq_cnt <= r_seq_cnt + 8'd1;
      r_rd_seq  <= r_seq_cnt;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  logic [2*SW-1:0] r_rd_data;
  logic [AW-1:0]   w_rd_addr;

  assign w_rd_addr = rd_idx[AW-1:0];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_idx < IW'(FRAME_LEN)) begin
      r_rd_data <= r_mem[r_bank_sel][w_rd_addr];
`ifdef CIC_FRAME_HDR_EN
    end else if (rd_idx == IW'(FRAME_LEN)) begin
      r_rd_data <= {16'hA55A, r_rd_seq, r_drop_cnt, {(2 * SW - 32){1'b0}}};
`endif
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rd_data     = r_rd_data;
  assign frame_ready = (r_state == StReady);
  assign drop_cnt    = r_drop_cnt;
  assign wr_level    = r_wr_ptr;

endmodule

// File: tb/tb_cic_frame_buffer.sv
// Testbench for cic_frame_buffer: frame capture, publish latency, drop on an
// unacknowledged read bank, ack/complete collision, en abort, async reset and
// the optional header word (CIC_FRAME_HDR_EN).
`timescale 1ns/1ps

module tb_cic_frame_buffer;

  localparam int unsigned SW = 24;
  localparam int unsigned IW = 6;
  localparam int unsigned FL = 36;

  logic            sys_clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            fdown = 1'b0;
  logic [SW-1:0]   cic_out1 = '0;
  logic [SW-1:0]   cic_out2 = '0;
  logic [IW-1:0]   rd_idx = '0;
  logic [2*SW-1:0] rd_data;
  logic            frame_ready;
  logic            frame_ack = 1'b0;
  logic [7:0]      drop_cnt;
  logic [IW-1:0]   wr_level;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*SW-1:0] exp_q[$];

  cic_frame_buffer #(
    .OSR       (64),
    .BIT       (12),
    .FRAME_LEN (FL)
  ) u_dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .en          (en),
    .fdown       (fdown),
    .cic_out1    (cic_out1),
    .cic_out2    (cic_out2),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .drop_cnt    (drop_cnt),
    .wr_level    (wr_level)
  );

  always #2.5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*SW-1:0] pair(input int a, input int b);
    return {SW'(a), SW'(b)};
  endfunction

  function automatic logic [2*SW-1:0] hdr(input int seq, input int drop);
    logic [2*SW-1:0] h;
    h = {16'hA55A, 8'(seq), 8'(drop), 16'h0000};
`ifndef CIC_FRAME_HDR_EN
    h = '0;
`endif
    return h;
  endfunction

  // Expected word is queued when rd_idx is driven, checked when it emerges.
  task automatic rd_check(input string tag, input int idx, input logic [2*SW-1:0] exp);
    @(posedge sys_clk); #1;
    rd_idx = IW'(idx);
    exp_q.push_back(exp);
    @(posedge sys_clk); #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      check_eq(tag, 64'(rd_data), 64'(exp_q.pop_front()));
    end
  endtask

  // One fdown period; optionally pulses frame_ack in the cycle the pair is
  // written (third sys_clk edge after the fdown rise).
  task automatic send_pair(input logic [SW-1:0] a, input logic [SW-1:0] b, input bit ack_at_tick);
    @(posedge sys_clk); #1;
    cic_out1 = a;
    cic_out2 = b;
    fdown    = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk); #1;
    if (ack_at_tick) frame_ack = 1'b1;
    @(posedge sys_clk); #1;
    frame_ack = 1'b0;
    @(posedge sys_clk); #1;
    fdown = 1'b0;
    repeat (4) @(posedge sys_clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge sys_clk); #1;
    check_eq("rst_ready", 64'(frame_ready), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    check_eq("rst_level", 64'(wr_level), 64'd0);
    check_eq("rst_data", 64'(rd_data), 64'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Frame A: k / 1000+k, publish latency on the last pair
    for (int k = 0; k < FL - 1; k++) begin
      send_pair(SW'(k), SW'(1000 + k), 1'b0);
      if (k == 9) begin
        #1 check_eq("level_10", 64'(wr_level), 64'd10);
      end
    end
    @(posedge sys_clk); #1;
    cic_out1 = SW'(35);
    cic_out2 = SW'(1035);
    fdown    = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk); #1;
    check_eq("ready_early", 64'(frame_ready), 64'd0);
    @(posedge sys_clk); #1;
    check_eq("ready_latency", 64'(frame_ready), 64'd1);
    check_eq("level_wrap", 64'(wr_level), 64'd0);
    fdown = 1'b0;
    repeat (4) @(posedge sys_clk);
    rd_check("a_idx5", 5, pair(5, 1005));
    rd_check("a_idx0", 0, pair(0, 1000));
    rd_check("a_idx35", 35, pair(35, 1035));
    rd_check("a_hdr", 36, hdr(0, 0));
    rd_check("a_idx40", 40, '0);

    // Frame B unacked: dropped, read bank untouched
    for (int k = 0; k < FL; k++) send_pair('1, '1, 1'b0);
    #1;
    check_eq("b_drop", 64'(drop_cnt), 64'd1);
    check_eq("b_ready", 64'(frame_ready), 64'd1);
    rd_check("b_idx0", 0, pair(0, 1000));
    rd_check("b_idx20", 20, pair(20, 1020));

    // Frame C: ack coincides with completion
    for (int k = 0; k < FL - 1; k++) send_pair(SW'(200 + k), SW'(300 + k), 1'b0);
    send_pair(SW'(235), SW'(335), 1'b1);
    #1;
    check_eq("c_ready", 64'(frame_ready), 64'd1);
    check_eq("c_drop", 64'(drop_cnt), 64'd1);
    rd_check("c_idx3", 3, pair(203, 303));
    rd_check("c_idx35", 35, pair(235, 335));
    rd_check("c_hdr", 36, hdr(1, 1));

    // Ack, then abort a partial frame with en
    @(posedge sys_clk); #1;
    frame_ack = 1'b1;
    @(posedge sys_clk); #1;
    frame_ack = 1'b0;
    check_eq("ack_ready", 64'(frame_ready), 64'd0);
    for (int k = 0; k < 20; k++) send_pair(SW'(50 + k), SW'(60 + k), 1'b0);
    #1;
    check_eq("d_level20", 64'(wr_level), 64'd20);
    en = 1'b0;
    @(posedge sys_clk); #1;
    check_eq("d_level_drop", 64'(wr_level), 64'd0);
    check_eq("d_ready_hold", 64'(frame_ready), 64'd0);
    en = 1'b1;
    for (int k = 0; k < FL; k++) send_pair(SW'(7), SW'(7), 1'b0);
    #1;
    check_eq("d_ready", 64'(frame_ready), 64'd1);
    rd_check("d_idx0", 0, pair(7, 7));
    rd_check("d_idx19", 19, pair(7, 7));
    rd_check("d_idx35", 35, pair(7, 7));
    rd_check("d_hdr", 36, hdr(2, 1));

    // Async reset mid-frame while READY
    for (int k = 0; k < 10; k++) send_pair(SW'(k), SW'(k), 1'b0);
    #1;
    check_eq("e_level10", 64'(wr_level), 64'd10);
    rst_n = 1'b0;
    #1;
    check_eq("e_ready", 64'(frame_ready), 64'd0);
    check_eq("e_drop", 64'(drop_cnt), 64'd0);
    check_eq("e_level", 64'(wr_level), 64'd0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;

    // Ack while EMPTY is ignored; fresh frame restarts the sequence
    frame_ack = 1'b1;
    @(posedge sys_clk); #1;
    frame_ack = 1'b0;
    check_eq("f_ack_empty", 64'(frame_ready), 64'd0);
    for (int k = 0; k < FL; k++) send_pair(SW'(3 * k), SW'(500 - k), 1'b0);
    #1;
    check_eq("f_ready", 64'(frame_ready), 64'd1);
    rd_check("f_idx2", 2, pair(6, 498));
    rd_check("f_hdr", 36, hdr(0, 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cic_frame_buffer.md
Name: cic_frame_buffer

Overview:
- Ping-pong frame buffer between the two CIC decimators and the I2C slave transmitter.
- Captures one {ch1, ch2} CIC output pair per FDOWN tick and fills a write bank.
- After FRAME_LEN pairs the write bank is published to the I2C side as a stable, indexed read bank with a ready/ack handshake.
- Replaces ad-hoc array copying with a single-clock, race-free structure in the sys_clk domain.

Parameters:
- OSR, 64, CIC oversampling ratio; sets sample width.
- BIT, 12, DSM-recovered data width; sample width SW = BIT+2*clog2(OSR) (24 at defaults).
- FRAME_LEN, 36, sample pairs per frame; index width IW = clog2(FRAME_LEN+1) (6 at defaults).

Ports:
- sys_clk  input  1  system clock, 200 MHz; sole clock of the block.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable (sys_clk domain).
- fdown  input  1  CIC decimation clock from clk_gen; asynchronous to this block, treated as a strobe source.
- cic_out1  input  SW  channel-1 CIC output, stable for one full fdown period.
- cic_out2  input  SW  channel-2 CIC output.
- rd_idx  input  IW  read index from I2C slave.
- rd_data  output  2*SW  read-bank word {ch1, ch2} at rd_idx.
- frame_ready  output  1  read bank holds an unacknowledged frame.
- frame_ack  input  1  one-cycle pulse: I2C side has finished with the read bank.
- drop_cnt  output  8  count of discarded frames, saturating.
- wr_level  output  IW  pairs written into the current write bank.

Behaviour:
- Reset: all outputs 0; write pointer 0; bank select 0; sequence counter 0; read-side FSM EMPTY. Memory contents are don't-care.
- fdown sync: two-flop synchroniser, then rising-edge detect. Each detected edge produces a one-cycle tick, 3 sys_clk after the fdown rise.
- Capture: on tick with en=1, write {cic_out1, cic_out2} to write bank at wr_ptr, then increment wr_ptr. wr_level tracks wr_ptr.
- en=0: wr_ptr forced to 0 at the next clock; any partial frame is discarded; drop_cnt is not incremented; the read side is unaffected.
- Frame complete: a write at wr_ptr=FRAME_LEN-1 sets wr_ptr to 0 and evaluates publish in the same cycle.
- Read-side FSM states: EMPTY, READY.
  - EMPTY, frame complete -> swap banks, frame_ready=1, go to READY.
  - READY, frame_ack -> frame_ready=0, go to EMPTY.
  - READY, frame complete without ack in the same cycle -> no swap; the completed write bank is discarded and refilled from index 0; drop_cnt+1, saturating at 255; stay in READY.
  - Ack and frame complete in the same cycle -> ack takes priority, then swap; frame_ready stays 1; no drop.
  - frame_ack while EMPTY: ignored.
- Publish: every successful swap increments an 8-bit wrapping sequence counter.
- Read port: rd_data is registered with 1-cycle latency from rd_idx, reading the read bank. rd_idx >= FRAME_LEN returns 0, except as defined under the optional feature.
- Read-bank contents never change while in READY; the write side only touches the other bank.
- Reset asserted mid-frame: immediate return to reset state; a frame being read is lost and frame_ready drops asynchronously.

Optional Feature:
- Macro: CIC_FRAME_HDR_EN.
- Defined: rd_idx==FRAME_LEN returns header {16'hA55A, seq[7:0], drop_cnt[7:0], (2*SW-32) zero bits}, where seq is the sequence number of the current read bank. rd_idx > FRAME_LEN returns 0.
- Undefined: no sequence counter is built; rd_idx >= FRAME_LEN returns 0.

Test Plan:
- Reset then en=1; drive 36 fdown edges with cic_out1=k, cic_out2=1000+k (k=0..35) -> frame_ready rises 3 sys_clk after the 36th fdown rise; rd_idx=5 gives rd_data={24'd5, 24'd1005} one cycle later.
- Hold frame unacked; feed a second 36-pair frame of 0xFFFFFF -> drop_cnt=1, frame_ready stays 1, rd_idx=0 still returns {24'd0, 24'd1000}.
- Ack in the exact cycle the next frame completes -> frame_ready stays 1, drop_cnt unchanged, read bank now shows the new frame.
- Drop en after 20 pairs, re-raise, write 36 pairs of value 7 -> wr_level returns to 0 at drop; published frame is all 7s, with none of the earlier 20 values.
- Assert rst_n=0 during READY at pair 10 of the next frame -> frame_ready=0, drop_cnt=0, wr_level=0 immediately.
- With CIC_FRAME_HDR_EN: after the 3rd publish with 1 drop, rd_idx=36 -> {16'hA55A, 8'd2, 8'd1, 16'h0}. Without the macro -> 0.
